// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: state encoding,
// register-file constants and the source-operand match helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True when the ID instruction actually reads a source that the EX load writes.
  function automatic logic src_hit(input logic                  uses,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-status inputs and pipeline-register controls between the datapath
// and the hazard controller.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [REG_ADDR_W-1:0] ID_RegisterRs;
  logic [REG_ADDR_W-1:0] ID_RegisterRt;
  logic                  ID_UsesRs;
  logic                  ID_UsesRt;
  logic                  EX_MemRead;
  logic [REG_ADDR_W-1:0] EX_RegisterRt;
  logic                  ID_Jump;
  logic                  EX_BranchTaken;
  logic                  EX_MulDivStart;

  logic                  PC_Write;
  logic                  IF_ID_Write;
  logic                  IF_ID_flush;
  logic                  ID_EX_stall;
  logic                  ID_EX_flush;
  logic                  ID_EX_hold;
  logic                  EX_MEM_bubble;
  logic                  MD_busy;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  // Controller side.
  modport master (
    input  ID_RegisterRs, ID_RegisterRt, ID_UsesRs, ID_UsesRt,
           EX_MemRead, EX_RegisterRt, ID_Jump, EX_BranchTaken, EX_MulDivStart,
    output PC_Write, IF_ID_Write, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           ID_EX_hold, EX_MEM_bubble, MD_busy, stall_cycles, flush_events
  );

  // Datapath side.
  modport slave (
    output ID_RegisterRs, ID_RegisterRt, ID_UsesRs, ID_UsesRt,
           EX_MemRead, EX_RegisterRt, ID_Jump, EX_BranchTaken, EX_MulDivStart,
    input  PC_Write, IF_ID_Write, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           ID_EX_hold, EX_MEM_bubble, MD_busy, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance-debug event counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, jump/branch
// flushes, mul/div front-end freeze and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.master bus
);

  localparam int MD_W = $clog2(MULDIV_CYCLES);
  localparam logic [MD_W-1:0] MD_INIT = MD_W'(MULDIV_CYCLES - 2);

  md_state_e       state;
  logic [MD_W-1:0] md_cnt;

  logic load_use;
  logic freeze;
  logic pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_flush;
  logic id_ex_hold, ex_mem_bubble;
  logic stall_inc, flush_inc;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_bubble = 1'b0;

    load_use = bus.EX_MemRead && (bus.EX_RegisterRt != REG_ZERO) &&
               (src_hit(bus.ID_UsesRs, bus.ID_RegisterRs, bus.EX_RegisterRt) ||
                src_hit(bus.ID_UsesRt, bus.ID_RegisterRt, bus.EX_RegisterRt));
    freeze   = ((state == RUN) && bus.EX_MulDivStart) ||
               ((state == MD_BUSY) && (md_cnt != '0));

    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_hold    = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // A jump in ID waits here and flushes once the bubble clears the hazard.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_stall = 1'b1;
    end else if (bus.ID_Jump) begin
      if_id_flush = 1'b1;
    end

    stall_inc = freeze || id_ex_stall;
    flush_inc = if_id_flush || id_ex_flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.EX_MulDivStart) begin
            md_cnt <= MD_INIT;
            state  <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          // md_cnt == 0 is the final EX cycle: the pipeline advances this cycle.
          if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .cnt   (bus.flush_events)
  );

  assign bus.PC_Write      = pc_write;
  assign bus.IF_ID_Write   = if_id_write;
  assign bus.IF_ID_flush   = if_id_flush;
  assign bus.ID_EX_stall   = id_ex_stall;
  assign bus.ID_EX_flush   = id_ex_flush;
  assign bus.ID_EX_hold    = id_ex_hold;
  assign bus.EX_MEM_bubble = ex_mem_bubble;
  assign bus.MD_busy       = (state == MD_BUSY);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with a 4-cycle mul/div
// and one with a 2-cycle mul/div, both with 4-bit counters.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) busa ();
  pipeline_hazard_ctrl_if #(.CNT_W(4)) busb ();

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(busa.master));
  pipeline_hazard_ctrl #(.MULDIV_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(busb.master));

  // Control bits: PC_Write, IF_ID_Write, IF_ID_flush, ID_EX_stall,
  //               ID_EX_flush, ID_EX_hold, EX_MEM_bubble, MD_busy
  localparam logic [7:0] C_IDLE = 8'b1100_0000;
  localparam logic [7:0] C_LU   = 8'b0001_0000;
  localparam logic [7:0] C_BR   = 8'b1110_1000;
  localparam logic [7:0] C_JMP  = 8'b1110_0000;
  localparam logic [7:0] C_FRZ0 = 8'b0000_0110;
  localparam logic [7:0] C_FRZ1 = 8'b0000_0111;
  localparam logic [7:0] C_LAST = 8'b1100_0001;

  logic [7:0] ctl_a, ctl_b;
  assign ctl_a = {busa.PC_Write, busa.IF_ID_Write, busa.IF_ID_flush, busa.ID_EX_stall,
                  busa.ID_EX_flush, busa.ID_EX_hold, busa.EX_MEM_bubble, busa.MD_busy};
  assign ctl_b = {busb.PC_Write, busb.IF_ID_Write, busb.IF_ID_flush, busb.ID_EX_stall,
                  busb.ID_EX_flush, busb.ID_EX_hold, busb.EX_MEM_bubble, busb.MD_busy};

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(busa.MD_busy && busa.EX_BranchTaken))
        else $error("illegal EX_BranchTaken while mul/div busy (dut_a)");
      assert (!(busb.MD_busy && busb.EX_BranchTaken))
        else $error("illegal EX_BranchTaken while mul/div busy (dut_b)");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urs, input logic urt,
                         input logic jmp, input logic br, input logic md);
    busa.EX_MemRead = mr;  busa.EX_RegisterRt = ert;
    busa.ID_RegisterRs = rs; busa.ID_RegisterRt = rt;
    busa.ID_UsesRs = urs; busa.ID_UsesRt = urt;
    busa.ID_Jump = jmp; busa.EX_BranchTaken = br; busa.EX_MulDivStart = md;
  endtask

  task automatic idle_all();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    busb.EX_MemRead = 0; busb.EX_RegisterRt = 0; busb.ID_RegisterRs = 0;
    busb.ID_RegisterRt = 0; busb.ID_UsesRs = 0; busb.ID_UsesRt = 0;
    busb.ID_Jump = 0; busb.EX_BranchTaken = 0; busb.EX_MulDivStart = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cmp_ctl_a(input string name, input logic [7:0] exp);
    #2;
    checks++;
    if (ctl_a !== exp) begin
      errors++;
      $display("FAIL %s: ctl_a got %b expected %b", name, ctl_a, exp);
    end
  endtask

  task automatic cmp_cnt_a(input string name, input logic [3:0] exp_s, input logic [3:0] exp_f);
    checks++;
    if (busa.stall_cycles !== exp_s || busa.flush_events !== exp_f) begin
      errors++;
      $display("FAIL %s: stall/flush got %0d/%0d expected %0d/%0d", name,
               busa.stall_cycles, busa.flush_events, exp_s, exp_f);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmp_ctl_a("reset_ctl_a", C_IDLE);
    cmp_cnt_a("reset_cnt_a", 4'd0, 4'd0);
    checks++;
    if (ctl_b !== C_IDLE || busb.stall_cycles !== 4'd0 || busb.flush_events !== 4'd0) begin
      errors++;
      $display("FAIL reset_b: ctl %b stall %0d flush %0d expected %b 0 0",
               ctl_b, busb.stall_cycles, busb.flush_events, C_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive_a(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    cmp_ctl_a("lu_rs_stall", C_LU);
    tick();
    drive_a(0, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    cmp_ctl_a("lu_bubble_clears", C_IDLE);
    cmp_cnt_a("lu_rs_count", 4'd1, 4'd0);
    tick();
    drive_a(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    cmp_ctl_a("lu_r0_no_stall", C_IDLE);
    tick();
    drive_a(1, 5'd9, 5'd3, 5'd9, 1, 1, 0, 0, 0);
    cmp_ctl_a("lu_rt_stall", C_LU);
    tick();
    drive_a(1, 5'd7, 5'd7, 5'd2, 0, 1, 0, 0, 0);
    cmp_ctl_a("lu_rs_unused", C_IDLE);
    tick();
    cmp_cnt_a("lu_count_after", 4'd2, 4'd0);
  endtask

  task automatic test_branch();
    drive_a(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0);
    cmp_ctl_a("branch_over_lu", C_BR);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_cnt_a("branch_count", 4'd2, 4'd1);
  endtask

  task automatic test_jump();
    drive_a(1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 0, 0);
    cmp_ctl_a("jump_held_by_lu", C_LU);
    tick();
    drive_a(0, 5'd0, 5'd4, 5'd0, 1, 0, 1, 0, 0);
    cmp_ctl_a("jump_retry_flush", C_JMP);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_cnt_a("jump_count", 4'd3, 4'd2);
  endtask

  task automatic test_muldiv();
    do_reset();
    // Branch, jump and load-use during the freeze must all be ignored.
    drive_a(1, 5'd6, 5'd6, 5'd0, 1, 0, 1, 1, 1);
    cmp_ctl_a("md4_c1", C_FRZ0);
    tick();
    drive_a(1, 5'd6, 5'd6, 5'd0, 1, 0, 1, 0, 1);
    cmp_ctl_a("md4_c2", C_FRZ1);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cmp_ctl_a("md4_c3", C_FRZ1);
    tick();
    cmp_ctl_a("md4_c4_last", C_LAST);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_ctl_a("md4_c5_run", C_IDLE);
    cmp_cnt_a("md4_count", 4'd3, 4'd0);
    tick();

    busb.EX_MulDivStart = 1'b1;
    #2;
    checks++;
    if (ctl_b !== C_FRZ0) begin errors++; $display("FAIL md2_c1: got %b expected %b", ctl_b, C_FRZ0); end
    tick();
    #2;
    checks++;
    if (ctl_b !== C_LAST) begin errors++; $display("FAIL md2_c2_last: got %b expected %b", ctl_b, C_LAST); end
    tick();
    busb.EX_MulDivStart = 1'b0;
    #2;
    checks++;
    if (ctl_b !== C_IDLE || busb.stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL md2_done: ctl %b stall %0d expected %b 1", ctl_b, busb.stall_cycles, C_IDLE);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [8];
    exp_seq = '{C_FRZ0, C_FRZ1, C_FRZ1, C_LAST, C_FRZ0, C_FRZ1, C_FRZ1, C_LAST};
    do_reset();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cmp_ctl_a($sformatf("b2b_c%0d", i + 1), exp_seq[i]);
      tick();
    end
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_ctl_a("b2b_run", C_IDLE);
    cmp_cnt_a("b2b_count", 4'd6, 4'd0);
    tick();
  endtask

  task automatic test_reset_in_md();
    do_reset();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cmp_ctl_a("rmd_c1", C_FRZ0);
    tick();
    reset = 1'b1;
    cmp_ctl_a("rmd_c2_busy", C_FRZ1);
    tick();
    reset = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp_ctl_a("rmd_after_reset", C_IDLE);
    cmp_cnt_a("rmd_counters", 4'd0, 4'd0);
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drive_a(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) tick();
    cmp_cnt_a("sat_14", 4'd14, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_cnt_a($sformatf("sat_hold_%0d", i), 4'd15, 4'd0);
    end
    drive_a(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) tick();
    cmp_cnt_a("sat_flush", 4'd15, 4'd15);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_muldiv();
    test_back_to_back();
    test_reset_in_md();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
